// File: rtl/stack_fsm.sv
// Main control sequencer for the StackArch CPU: a Moore machine that walks the
// fixed fetch/decode/pop/pop/execute/push cycle and decodes every datapath strobe.
module stack_fsm (
    input  logic clk,
    input  logic rst,
    output logic rst_temp1,
    output logic rst_temp2,
    output logic rd_temp1,
    output logic rd_temp2,
    output logic wr_temp1,
    output logic wr_temp2,
    output logic rd_ir,
    output logic wr_ir,
    output logic rst_ir,
    output logic rst_tos,
    output logic rst_flags,
    output logic rd_mem,
    output logic wr_mem,
    output logic rd_ip,
    output logic wr_ip,
    output logic rst_ip,
    output logic inc_ip,
    output logic push_stack,
    output logic pop_stack,
    output logic rst_stack,
    output logic push_rtn,
    output logic pop_rtn,
    output logic rst_rtn
);

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_RST     = 4'd0;
    localparam logic [STATE_W-1:0] ST_FETCH   = 4'd1;
    localparam logic [STATE_W-1:0] ST_LOAD_IR = 4'd2;
    localparam logic [STATE_W-1:0] ST_INC_IP  = 4'd3;
    localparam logic [STATE_W-1:0] ST_POP_A   = 4'd4;
    localparam logic [STATE_W-1:0] ST_POP_B   = 4'd5;
    localparam logic [STATE_W-1:0] ST_EXEC    = 4'd6;
    localparam logic [STATE_W-1:0] ST_PUSH    = 4'd7;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // State register; reset aborts the cycle at the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; illegal encodings fall back to RST with all strobes low.
    always_comb begin
        state_d    = ST_RST;
        rst_temp1  = 1'b0;
        rst_temp2  = 1'b0;
        rd_temp1   = 1'b0;
        rd_temp2   = 1'b0;
        wr_temp1   = 1'b0;
        wr_temp2   = 1'b0;
        rd_ir      = 1'b0;
        wr_ir      = 1'b0;
        rst_ir     = 1'b0;
        rst_tos    = 1'b0;
        rst_flags  = 1'b0;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        rd_ip      = 1'b0;
        wr_ip      = 1'b0;
        rst_ip     = 1'b0;
        inc_ip     = 1'b0;
        push_stack = 1'b0;
        pop_stack  = 1'b0;
        rst_stack  = 1'b0;
        push_rtn   = 1'b0;
        pop_rtn    = 1'b0;
        rst_rtn    = 1'b0;

        case (state_q)
            ST_RST: begin
                state_d   = ST_FETCH;
                rst_temp1 = 1'b1;
                rst_temp2 = 1'b1;
                rst_ir    = 1'b1;
                rst_tos   = 1'b1;
                rst_flags = 1'b1;
                rst_ip    = 1'b1;
                rst_stack = 1'b1;
                rst_rtn   = 1'b1;
            end
            ST_FETCH: begin
                state_d = ST_LOAD_IR;
                rd_ip   = 1'b1;
                rd_mem  = 1'b1;
            end
            ST_LOAD_IR: begin
                state_d = ST_INC_IP;
                rd_mem  = 1'b1;
                wr_ir   = 1'b1;
            end
            ST_INC_IP: begin
                state_d = ST_POP_A;
                inc_ip  = 1'b1;
            end
            ST_POP_A: begin
                state_d   = ST_POP_B;
                pop_stack = 1'b1;
                wr_temp1  = 1'b1;
            end
            ST_POP_B: begin
                state_d   = ST_EXEC;
                pop_stack = 1'b1;
                wr_temp2  = 1'b1;
            end
            ST_EXEC: begin
                state_d  = ST_PUSH;
                rd_temp1 = 1'b1;
                rd_temp2 = 1'b1;
                rd_ir    = 1'b1;
            end
            ST_PUSH: begin
                state_d    = ST_FETCH;
                push_stack = 1'b1;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_fsm.sv
// Directed plus randomized-reset bench for stack_fsm, checked against a
// position-in-instruction-cycle model of the sequencer.
module tb_stack_fsm;

    logic clk;
    logic rst;
    logic rst_temp1, rst_temp2, rd_temp1, rd_temp2, wr_temp1, wr_temp2;
    logic rd_ir, wr_ir, rst_ir, rst_tos, rst_flags, rd_mem, wr_mem;
    logic rd_ip, wr_ip, rst_ip, inc_ip, push_stack, pop_stack, rst_stack;
    logic push_rtn, pop_rtn, rst_rtn;

    stack_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .rst_temp1  (rst_temp1),
        .rst_temp2  (rst_temp2),
        .rd_temp1   (rd_temp1),
        .rd_temp2   (rd_temp2),
        .wr_temp1   (wr_temp1),
        .wr_temp2   (wr_temp2),
        .rd_ir      (rd_ir),
        .wr_ir      (wr_ir),
        .rst_ir     (rst_ir),
        .rst_tos    (rst_tos),
        .rst_flags  (rst_flags),
        .rd_mem     (rd_mem),
        .wr_mem     (wr_mem),
        .rd_ip      (rd_ip),
        .wr_ip      (wr_ip),
        .rst_ip     (rst_ip),
        .inc_ip     (inc_ip),
        .push_stack (push_stack),
        .pop_stack  (pop_stack),
        .rst_stack  (rst_stack),
        .push_rtn   (push_rtn),
        .pop_rtn    (pop_rtn),
        .rst_rtn    (rst_rtn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int B_RST_TEMP1 = 22, B_RST_TEMP2 = 21, B_RD_TEMP1 = 20, B_RD_TEMP2 = 19;
    localparam int B_WR_TEMP1 = 18, B_WR_TEMP2 = 17, B_RD_IR = 16, B_WR_IR = 15;
    localparam int B_RST_IR = 14, B_RST_TOS = 13, B_RST_FLAGS = 12, B_RD_MEM = 11;
    localparam int B_WR_MEM = 10, B_RD_IP = 9, B_WR_IP = 8, B_RST_IP = 7, B_INC_IP = 6;
    localparam int B_PUSH = 5, B_POP = 4, B_RST_STACK = 3, B_PUSH_RTN = 2;
    localparam int B_POP_RTN = 1, B_RST_RTN = 0;

    logic [22:0] obs;
    assign obs = {rst_temp1, rst_temp2, rd_temp1, rd_temp2, wr_temp1, wr_temp2,
                  rd_ir, wr_ir, rst_ir, rst_tos, rst_flags, rd_mem, wr_mem,
                  rd_ip, wr_ip, rst_ip, inc_ip, push_stack, pop_stack, rst_stack,
                  push_rtn, pop_rtn, rst_rtn};

    logic [22:0] rst_mask;
    logic [22:0] rsv_mask;

    int checks;
    int failures;
    // Model: -1 is the reset state, 0..6 is the position within the 7-step instruction cycle.
    int pos;
    int push_cnt;
    int pop_cnt;
    int pop_pair;
    logic [22:0] hist [0:19];

    function automatic logic [22:0] expected_outputs(input int p);
        logic [22:0] v;
        v = '0;
        case (p)
            -1: begin
                v[B_RST_TEMP1] = 1'b1; v[B_RST_TEMP2] = 1'b1; v[B_RST_IR] = 1'b1;
                v[B_RST_TOS] = 1'b1; v[B_RST_FLAGS] = 1'b1; v[B_RST_IP] = 1'b1;
                v[B_RST_STACK] = 1'b1; v[B_RST_RTN] = 1'b1;
            end
            0: begin v[B_RD_IP] = 1'b1; v[B_RD_MEM] = 1'b1; end
            1: begin v[B_RD_MEM] = 1'b1; v[B_WR_IR] = 1'b1; end
            2: v[B_INC_IP] = 1'b1;
            3: begin v[B_POP] = 1'b1; v[B_WR_TEMP1] = 1'b1; end
            4: begin v[B_POP] = 1'b1; v[B_WR_TEMP2] = 1'b1; end
            5: begin v[B_RD_TEMP1] = 1'b1; v[B_RD_TEMP2] = 1'b1; v[B_RD_IR] = 1'b1; end
            6: v[B_PUSH] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: drive rst away from the edge, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic r, input string tag);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        #1;
        if (r) pos = -1;
        else   pos = (pos == -1) ? 0 : (pos + 1) % 7;
        check(tag, obs, expected_outputs(pos));
        check({tag, "_pushpop_excl"}, 23'(push_stack & pop_stack), 23'd0);
        check({tag, "_reserved"}, obs & rsv_mask, 23'd0);
        if ((obs & rst_mask) != 23'd0)
            check({tag, "_rst_excl"}, obs & ~rst_mask, 23'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pos      = -1;
        rst      = 1'b1;
        rst_mask = '0;
        rst_mask[B_RST_TEMP1] = 1'b1; rst_mask[B_RST_TEMP2] = 1'b1; rst_mask[B_RST_IR] = 1'b1;
        rst_mask[B_RST_TOS] = 1'b1; rst_mask[B_RST_FLAGS] = 1'b1; rst_mask[B_RST_IP] = 1'b1;
        rst_mask[B_RST_STACK] = 1'b1; rst_mask[B_RST_RTN] = 1'b1;
        rsv_mask = '0;
        rsv_mask[B_WR_MEM] = 1'b1; rsv_mask[B_WR_IP] = 1'b1;
        rsv_mask[B_PUSH_RTN] = 1'b1; rsv_mask[B_POP_RTN] = 1'b1;

        // Reset entry and hold.
        step(1'b1, "reset_entry");
        step(1'b1, "reset_hold");
        check("reset_vector", obs, rst_mask);

        // Fetch sequence then the full loop.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, "loop");
            hist[i] = obs;
        end
        check("fetch_1", hist[0], 23'h000A00);
        check("fetch_2", hist[1], 23'h008800);
        check("fetch_3", hist[2], 23'h000040);
        for (int w = 0; w < 2; w++) begin
            push_cnt = 0;
            pop_cnt  = 0;
            pop_pair = 0;
            for (int k = 0; k < 7; k++) begin
                push_cnt += int'(hist[w*7+k][B_PUSH]);
                pop_cnt  += int'(hist[w*7+k][B_POP]);
                if (k < 6 && hist[w*7+k][B_POP] && hist[w*7+k+1][B_POP]) pop_pair++;
            end
            check("push_once_per_7", 23'(push_cnt), 23'd1);
            check("pop_twice_per_7", 23'(pop_cnt), 23'd2);
            check("pop_consecutive", 23'(pop_pair), 23'd1);
        end

        // Mid-cycle reset while in POP_B.
        step(1'b1, "mid_pre_reset");
        for (int i = 0; i < 5; i++) step(1'b0, "mid_walk");
        check("mid_in_pop_b", 23'(pop_stack & wr_temp2), 23'd1);
        step(1'b1, "mid_abort");
        check("mid_abort_no_pop", 23'(pop_stack), 23'd0);
        step(1'b0, "mid_restart_fetch");
        check("mid_restart_rd_ip", 23'(rd_ip), 23'd1);

        // Free run: reserved strobes stay low.
        for (int i = 0; i < 50; i++) step(1'b0, "free_run");

        // Randomized reset pulses of random length.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
